alu_mul_sequencer: RTL and testbench
====================================

// Module: alu_mul_sequencer
// PURPOSE
//  Shift-add multiplier controller that sequences the shared combinational ALU.
//  Accepts one unsigned W x W multiply request, drives ALU op/operand ports one op
//  per clock (double add, double shift-left, single shift-right) and returns a 2W product.
//  Sits between the instruction-level datapath and the ALU; owns the ALU while busy.
// PARAMETERS
//  W   `b_width (16)   operand width; product is 2W; ALU half-word width
// PORTS
//  clk        in   1    system clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  req_valid  in   1    request present
//  req_ready  out  1    controller can accept (== state IDLE)
//  req_a      in   W    multiplicand, unsigned
//  req_b      in   W    multiplier, unsigned
//  rsp_valid  out  1    product valid (== state DONE)
//  rsp_ready  in   1    consumer accepts product
//  rsp_prod   out  2W   product {hi,lo}
//  busy       out  1    ALU owned (state ADD/SHL/SHR)
//  alu_op     out  4    ALU opcode
//  alu_ha/la  out  W    ALU A operand hi/lo
//  alu_hb/lb  out  W    ALU B operand hi/lo
//  alu_hc/lc  in   W    ALU result hi/lo
//  alu_zr     in   1    ALU zero flag (lc==0)
//  alu_carry  in   1    ALU carry out
// BEHAVIOUR
//  Registers: ACC(2W), MCAND(2W), MPLIER(W), state. ALU ports are combinational from
//   registered state; ALU result captured on the next rising edge (1 op/cycle).
//  Reset (async, rst_n=0): state=IDLE, ACC=MCAND=MPLIER=0 -> req_ready=1, rsp_valid=0,
//   busy=0, rsp_prod=0, alu_op=0, all alu operands 0. Inputs ignored while rst_n=0.
//  Reset mid-operation aborts; no product emitted; next request starts clean.
//  IDLE: accept on req_valid&&req_ready edge: ACC<=0, MCAND<={0,req_a}, MPLIER<=req_b;
//   next = DONE if req_b==0, else ADD if req_b[0], else SHL.
//  ADD: alu_op=8, {ha,la}=ACC, {hb,lb}=MCAND; ACC<={hc,lc}; next SHL.
//  SHL: alu_op=13, {hb,lb}=MCAND; MCAND<={hc,lc}; next SHR.
//  SHR: alu_op=4, lb=MPLIER; MPLIER<=lc; next DONE if alu_zr, else ADD if lc[0], else SHL.
//  DONE: rsp_valid=1, rsp_prod=ACC held stable until rsp_ready; on rsp_valid&&rsp_ready
//   edge -> IDLE. No new request accepted in same cycle as response handshake.
//  IDLE/DONE: alu_op=0, operands 0 (ALU free for other masters via external mux).
//  Unused ALU operands in ADD/SHL/SHR driven 0.
//  Latency: k = index of highest set bit of req_b +1, p = popcount(req_b), T = 2k+p;
//   rsp_valid rises T+1 clocks after accept edge (b==0: 1 clock). Max 49 for W=16.
//  Width rules: unsigned only; product always fits 2W so alu_carry in ADD must be 0;
//   simulation assertion fires if alu_carry=1 in ADD. MCAND shift drops bit 2W-1 (never set
//   while relevant). Safety counter: >W SHR states forces DONE and fires assertion.
//  req_a/req_b sampled only at accept; changes afterwards have no effect.
// TESTING
//  a=3, b=5 -> rsp_valid 9 clk after accept, rsp_prod=0x0000000F, op seq 8,13,4,13,4,8,13,4.
//  a=0xFFFF, b=0xFFFF -> rsp_valid after 49 clk, rsp_prod=0xFFFE0001, alu_carry never 1.
//  a=0x1234, b=0 -> rsp_valid after 1 clk, rsp_prod=0, busy never 1, alu_op stays 0.
//  a=0, b=0x8000 -> 34 clk, rsp_prod=0; then hold rsp_ready=0 10 clk -> rsp_prod stable, req_ready=0.
//  Back-to-back: two requests with req_valid held -> second accepted only after rsp handshake.
//  Deassert rst_n in SHL of a=7,b=9 -> outputs reset immediately; next a=2,b=3 -> product 6.

Source files
------------

// File: rtl/alu_mul_sequencer_if.sv
// Request/response handshake bundle between a multiply requester and the
// shift-add multiplier controller.
interface alu_mul_sequencer_if #(
  parameter int W = 16
);
  logic           req_valid;
  logic           req_ready;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*W-1:0] rsp_prod;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_prod
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_prod
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier controller: borrows the shared combinational ALU one op per
// clock (double add, double shift-left, single shift-right) to form a 2W product.
module alu_mul_sequencer #(
  parameter int W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_mul_sequencer_if.slave bus,
  output logic               busy,
  output logic [3:0]         alu_op,
  output logic [W-1:0]       alu_ha,
  output logic [W-1:0]       alu_la,
  output logic [W-1:0]       alu_hb,
  output logic [W-1:0]       alu_lb,
  input  logic [W-1:0]       alu_hc,
  input  logic [W-1:0]       alu_lc,
  input  logic               alu_zr,
  input  logic               alu_carry
);

  localparam logic [3:0] OP_ADD2 = 4'd8;
  localparam logic [3:0] OP_SHL2 = 4'd13;
  localparam logic [3:0] OP_SHR1 = 4'd4;
  localparam int         CW      = $clog2(W + 1);
  localparam logic [CW-1:0] SHR_MAX = CW'(W);

  typedef enum logic [2:0] {IDLE, ADD, SHL, SHR, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  shr_cnt;
  logic           req_ready_r;
  logic           rsp_valid_r;
  logic           shr_limit;

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_prod  = acc;

  // A multiplier never needs more than W shift-rights; beyond that something is broken.
  assign shr_limit = (state == SHR) && (shr_cnt >= SHR_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_b == '0)  state_nxt = DONE;
          else if (bus.req_b[0]) state_nxt = ADD;
          else                   state_nxt = SHL;
        end
      end
      ADD: state_nxt = SHL;
      SHL: state_nxt = SHR;
      SHR: begin
        if (shr_limit || alu_zr) state_nxt = DONE;
        else if (alu_lc[0])      state_nxt = ADD;
        else                     state_nxt = SHL;
      end
      DONE: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      shr_cnt     <= '0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      req_ready_r <= (state_nxt == IDLE);
      rsp_valid_r <= (state_nxt == DONE);
      busy        <= (state_nxt == ADD) || (state_nxt == SHL) || (state_nxt == SHR);
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            acc     <= '0;
            mcand   <= {{W{1'b0}}, bus.req_a};
            mplier  <= bus.req_b;
            shr_cnt <= '0;
          end
        end
        ADD: acc <= {alu_hc, alu_lc};
        SHL: mcand <= {alu_hc, alu_lc};
        SHR: begin
          mplier  <= alu_lc;
          shr_cnt <= shr_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // ALU operands decode straight from registered state; idle states release the ALU.
  always_comb begin
    alu_op = '0;
    alu_ha = '0;
    alu_la = '0;
    alu_hb = '0;
    alu_lb = '0;
    case (state)
      ADD: begin
        alu_op           = OP_ADD2;
        {alu_ha, alu_la} = acc;
        {alu_hb, alu_lb} = mcand;
      end
      SHL: begin
        alu_op           = OP_SHL2;
        {alu_hb, alu_lb} = mcand;
      end
      SHR: begin
        alu_op = OP_SHR1;
        alu_lb = mplier;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && state == ADD)
      assert (!alu_carry) else $error("alu_mul_sequencer: carry out during accumulate");
    if (rst_n)
      assert (!shr_limit) else $error("alu_mul_sequencer: shift-right limit exceeded");
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural model of the shared ALU.
module tb_alu_mul_sequencer;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mul_sequencer_if #(.W(W)) bus ();

  logic           busy;
  logic [3:0]     alu_op;
  logic [W-1:0]   alu_ha, alu_la, alu_hb, alu_lb, alu_hc, alu_lc;
  logic           alu_zr, alu_carry;
  logic [2*W:0]   alu_sum;
  logic [2*W-1:0] alu_shl;

  alu_mul_sequencer #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .alu_op    (alu_op),
    .alu_ha    (alu_ha),
    .alu_la    (alu_la),
    .alu_hb    (alu_hb),
    .alu_lb    (alu_lb),
    .alu_hc    (alu_hc),
    .alu_lc    (alu_lc),
    .alu_zr    (alu_zr),
    .alu_carry (alu_carry)
  );

  // Shared ALU: 8 = 2W add, 13 = 2W shift-left of B, 4 = W shift-right of lb.
  always_comb begin
    alu_sum   = {1'b0, alu_ha, alu_la} + {1'b0, alu_hb, alu_lb};
    alu_shl   = {alu_hb, alu_lb} << 1;
    alu_hc    = '0;
    alu_lc    = '0;
    alu_carry = 1'b0;
    case (alu_op)
      4'd8:    {alu_carry, alu_hc, alu_lc} = alu_sum;
      4'd13:   {alu_hc, alu_lc} = alu_shl;
      4'd4:    alu_lc = alu_lb >> 1;
      default: ;
    endcase
    alu_zr = (alu_lc == '0);
  end

  int tests = 0;
  int fails = 0;
  int ops [64];
  int nops;
  bit carry_seen, busy_seen, opnz_seen;
  int exp_ops [8] = '{8, 13, 4, 13, 4, 8, 13, 4};

  initial begin
    #100000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string t, input logic [63:0] o, input logic [63:0] e);
    tests++;
    if (o !== e) begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    nops = 0;
    carry_seen = 0;
    busy_seen = 0;
    opnz_seen = 0;
  endtask

  task automatic sample();
    if (busy && nops < 64) begin
      ops[nops] = int'(alu_op);
      nops++;
    end
    if (busy) busy_seen = 1;
    if (alu_op != 4'd0) opnz_seen = 1;
    if (alu_op == 4'd8 && alu_carry) carry_seen = 1;
  endtask

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    clear_flags();
    while (!bus.req_ready && n < 100) begin
      tick();
      n++;
    end
    chk("start_ready", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_a = a;
    bus.req_b = b;
    tick();
    bus.req_valid = 1'b0;
    sample();
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat, input logic [2*W-1:0] exp_prod);
    int lat = 1;
    while (!bus.rsp_valid && lat < 100) begin
      tick();
      sample();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_prod"}, 64'(bus.rsp_prod), 64'(exp_prod));
  endtask

  task automatic handshake(input string tag);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk({tag, "_rsp_clear"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_ready_back"}, 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    clear_flags();

    // Reset values
    #12;
    tests++;
    if (bus.req_ready !== 1'b1) begin fails++; $error("FAIL rst_req_ready observed=%0h", bus.req_ready); end
    tests++;
    if (bus.rsp_valid !== 1'b0) begin fails++; $error("FAIL rst_rsp_valid observed=%0h", bus.rsp_valid); end
    tests++;
    if (busy !== 1'b0) begin fails++; $error("FAIL rst_busy observed=%0h", busy); end
    tests++;
    if (bus.rsp_prod !== 32'h0) begin fails++; $error("FAIL rst_prod observed=%0h", bus.rsp_prod); end
    tests++;
    if (alu_op !== 4'h0) begin fails++; $error("FAIL rst_alu_op observed=%0h", alu_op); end
    tests++;
    if ({alu_ha, alu_la, alu_hb, alu_lb} !== 64'h0) begin
      fails++;
      $error("FAIL rst_operands observed=%0h", {alu_ha, alu_la, alu_hb, alu_lb});
    end
    rst_n = 1'b1;
    tick();

    // 3 x 5 with op sequence
    start(16'd3, 16'd5);
    wait_rsp("m3x5", 9, 32'h0000000F);
    tests++;
    if (nops !== 8) begin fails++; $error("FAIL m3x5_nops observed=%0d expected=8", nops); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (ops[i] !== exp_ops[i]) begin
        fails++;
        $error("FAIL m3x5_op%0d observed=%0d expected=%0d", i, ops[i], exp_ops[i]);
      end
    end
    handshake("m3x5");

    // Full-scale operands
    start(16'hFFFF, 16'hFFFF);
    wait_rsp("mffff", 49, 32'hFFFE0001);
    tests++;
    if (carry_seen !== 1'b0) begin fails++; $error("FAIL mffff_carry observed=%0h", carry_seen); end
    handshake("mffff");

    // Zero multiplier never touches the ALU
    start(16'h1234, 16'h0000);
    wait_rsp("bzero", 1, 32'h0);
    tests++;
    if (busy_seen !== 1'b0) begin fails++; $error("FAIL bzero_busy observed=%0h", busy_seen); end
    tests++;
    if (opnz_seen !== 1'b0) begin fails++; $error("FAIL bzero_op observed=%0h", opnz_seen); end
    handshake("bzero");

    // Zero multiplicand, top multiplier bit, then response back-pressure
    start(16'h0000, 16'h8000);
    wait_rsp("azero", 34, 32'h0);
    bus.req_valid = 1'b1;
    bus.req_a = 16'd6;
    bus.req_b = 16'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (bus.rsp_prod !== 32'h0) begin fails++; $error("FAIL hold_prod observed=%0h", bus.rsp_prod); end
      tests++;
      if (bus.req_ready !== 1'b0) begin fails++; $error("FAIL hold_req_ready observed=%0h", bus.req_ready); end
      tests++;
      if (bus.rsp_valid !== 1'b1) begin fails++; $error("FAIL hold_rsp_valid observed=%0h", bus.rsp_valid); end
    end

    // Back-to-back: held request must wait for the response handshake
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    tests++;
    if (bus.rsp_valid !== 1'b0) begin fails++; $error("FAIL b2b_rsp_clear observed=%0h", bus.rsp_valid); end
    tests++;
    if (bus.req_ready !== 1'b1) begin fails++; $error("FAIL b2b_idle_ready observed=%0h", bus.req_ready); end
    tests++;
    if (busy !== 1'b0) begin fails++; $error("FAIL b2b_not_busy observed=%0h", busy); end
    clear_flags();
    tick();
    bus.req_valid = 1'b0;
    sample();
    tests++;
    if (bus.req_ready !== 1'b0) begin fails++; $error("FAIL b2b_accepted observed=%0h", bus.req_ready); end
    wait_rsp("b2b_6x7", 10, 32'd42);
    handshake("b2b_6x7");

    // Asynchronous reset in the middle of an operation
    start(16'd7, 16'd9);
    tick();
    tests++;
    if (alu_op !== 4'd13) begin fails++; $error("FAIL abort_in_shl observed=%0h", alu_op); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.req_ready !== 1'b1) begin fails++; $error("FAIL abort_req_ready observed=%0h", bus.req_ready); end
    tests++;
    if (busy !== 1'b0) begin fails++; $error("FAIL abort_busy observed=%0h", busy); end
    tests++;
    if (bus.rsp_valid !== 1'b0) begin fails++; $error("FAIL abort_rsp_valid observed=%0h", bus.rsp_valid); end
    tests++;
    if (bus.rsp_prod !== 32'h0) begin fails++; $error("FAIL abort_prod observed=%0h", bus.rsp_prod); end
    tests++;
    if (alu_op !== 4'h0) begin fails++; $error("FAIL abort_alu_op observed=%0h", alu_op); end
    #1;
    rst_n = 1'b1;
    tick();
    start(16'd2, 16'd3);
    wait_rsp("post_abort", 7, 32'd6);
    handshake("post_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
